// File: rtl/usb_ep_pkg.sv
// Shared types for the USB endpoint transaction sequencer.
// Optional stall support in the top is controlled by USB_EP_STALL_EN.
package usb_ep_pkg;

    localparam int unsigned MAX_EP_CNT = 16;

    typedef enum logic [1:0] {
        TOK_OUT   = 2'd0,
        TOK_IN    = 2'd1,
        TOK_SETUP = 2'd2
    } TokenType_t;

    typedef enum logic [1:0] {
        HS_ACK   = 2'd0,
        HS_NAK   = 2'd1,
        HS_STALL = 2'd2
    } Handshake_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OUT_DATA,
        ST_IN_SEND,
        ST_IN_WAIT_ACK
    } CtrlState_t;

endpackage

// File: rtl/usb_ep_toggle_regs.sv
// DATA0/DATA1 toggle register file: one OUT and one IN bit per endpoint,
// with per-endpoint flip strobes and a set-both strobe used by SETUP.
module usb_ep_toggle_regs
    import usb_ep_pkg::*;
#(
    parameter int unsigned EP_CNT = 2
) (
    input  logic              clk48_i,
    input  logic              rst_n_i,
    input  logic [EP_CNT-1:0] flipOut,
    input  logic [EP_CNT-1:0] flipIn,
    input  logic [EP_CNT-1:0] setBoth,
    output logic [EP_CNT-1:0] outToggle,
    output logic [EP_CNT-1:0] inToggle
);

    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outToggle <= '0;
            inToggle  <= '0;
        end else begin
            outToggle <= setBoth | (outToggle ^ flipOut);
            inToggle  <= setBoth | (inToggle ^ flipIn);
        end
    end

endmodule

// File: rtl/usb_ep_trans_ctrl.sv
// Token-driven transaction sequencer between the packet engine and the endpoint FIFOs.
// Define USB_EP_STALL_EN to honour epStall_i and emit STALL handshakes.
module usb_ep_trans_ctrl
    import usb_ep_pkg::*;
#(
    parameter int unsigned EP_CNT = 2
) (
    input  logic                  clk48_i,
    input  logic                  rst_n_i,
    input  logic                  tokValid_i,
    input  logic [1:0]            tokType_i,
    input  logic [3:0]            tokEp_i,
    input  logic                  rxDataValid_i,
    input  logic [7:0]            rxData_i,
    input  logic                  rxIsData1_i,
    input  logic                  rxPacketDone_i,
    input  logic                  rxPacketOk_i,
    output logic                  txReq_o,
    output logic                  txIsData1_o,
    output logic                  txDataValid_o,
    output logic [7:0]            txData_o,
    input  logic                  txPop_i,
    input  logic                  txDone_i,
    input  logic                  hostAck_i,
    input  logic                  timeout_i,
    output logic                  hsValid_o,
    output logic [1:0]            hsCode_o,
    input  logic [EP_CNT-1:0]     epStall_i,
    output logic [EP_CNT-1:0]     EP_OUT_fillTransDone_o,
    output logic [EP_CNT-1:0]     EP_OUT_fillTransSuccess_o,
    output logic [EP_CNT-1:0]     EP_OUT_dataValid_o,
    output logic [7:0]            EP_OUT_data_o,
    input  logic [EP_CNT-1:0]     EP_OUT_full_i,
    output logic [EP_CNT-1:0]     EP_IN_popTransDone_o,
    output logic [EP_CNT-1:0]     EP_IN_popTransSuccess_o,
    output logic [EP_CNT-1:0]     EP_IN_popData_o,
    input  logic [EP_CNT-1:0]     EP_IN_dataAvailable_i,
    input  logic [8*EP_CNT-1:0]   EP_IN_data_i
);

    CtrlState_t        state, nextState;
    logic [3:0]        sel;
    logic              isSetup;
    logic              ovf;
    logic              pendValid;
    logic [1:0]        pendType;
    logic [3:0]        pendEp;

    logic              curValid;
    logic [1:0]        curType;
    logic [3:0]        curEp;
    logic              accept;
    logic [EP_CNT-1:0] curOneHot, selOneHot;
    logic              curStall, selStall, curAvail, selAvail, selFull;
    logic              curInTog, selOutTog;
    logic [7:0]        inByte;
    logic              writeEn, ovfNow, expData1;

    logic [EP_CNT-1:0] outToggle, inToggle, flipOut, flipIn, setBoth;

    logic              txReqD, txIsData1D, hsValidD;
    Handshake_t        hsCodeD;
    logic [EP_CNT-1:0] fillDoneD, fillSuccD, popDoneD, popSuccD;

    usb_ep_toggle_regs #(
        .EP_CNT(EP_CNT)
    ) uToggles (
        .clk48_i  (clk48_i),
        .rst_n_i  (rst_n_i),
        .flipOut  (flipOut),
        .flipIn   (flipIn),
        .setBoth  (setBoth),
        .outToggle(outToggle),
        .inToggle (inToggle)
    );

    // A token that aborted a transaction is replayed from the pending slot once back in IDLE.
    always_comb begin
        curValid  = tokValid_i | pendValid;
        curType   = tokValid_i ? tokType_i : pendType;
        curEp     = tokValid_i ? tokEp_i : pendEp;
        accept    = (state == ST_IDLE) && curValid && (32'(curEp) < EP_CNT) && (curType != 2'd3);
        curOneHot = '0;
        selOneHot = '0;
        inByte    = '0;
        for (int unsigned i = 0; i < EP_CNT; i++) begin
            curOneHot[i] = (curEp == 4'(i));
            selOneHot[i] = (sel == 4'(i));
            if (sel == 4'(i)) begin
                inByte = EP_IN_data_i[8*i +: 8];
            end
        end
    end

`ifdef USB_EP_STALL_EN
    assign curStall = |(epStall_i & curOneHot);
    assign selStall = |(epStall_i & selOneHot);
`else
    logic unusedStall;
    assign unusedStall = ^epStall_i;
    assign curStall    = 1'b0;
    assign selStall    = 1'b0;
`endif

    assign curAvail  = |(EP_IN_dataAvailable_i & curOneHot);
    assign selAvail  = |(EP_IN_dataAvailable_i & selOneHot);
    assign selFull   = |(EP_OUT_full_i & selOneHot);
    assign curInTog  = |(inToggle & curOneHot);
    assign selOutTog = |(outToggle & selOneHot);

    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (curType == TOK_IN) begin
                        if (!curStall && curAvail) begin
                            nextState = ST_IN_SEND;
                        end
                    end else begin
                        nextState = ST_OUT_DATA;
                    end
                end
            end
            ST_OUT_DATA: begin
                if (tokValid_i || rxPacketDone_i) begin
                    nextState = ST_IDLE;
                end
            end
            ST_IN_SEND: begin
                if (tokValid_i) begin
                    nextState = ST_IDLE;
                end else if (txDone_i) begin
                    nextState = ST_IN_WAIT_ACK;
                end
            end
            ST_IN_WAIT_ACK: begin
                if (tokValid_i || hostAck_i || timeout_i) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        writeEn            = (state == ST_OUT_DATA) && rxDataValid_i && !ovf && !selFull;
        EP_OUT_dataValid_o = writeEn ? selOneHot : '0;
        EP_OUT_data_o      = writeEn ? rxData_i : '0;
        txDataValid_o      = (state == ST_IN_SEND) && selAvail;
        txData_o           = (state == ST_IN_SEND) ? inByte : '0;
        EP_IN_popData_o    = ((state == ST_IN_SEND) && txPop_i) ? selOneHot : '0;

        // A full FIFO on the final byte must still count as overflow for this commit.
        ovfNow   = ovf | (rxDataValid_i & selFull);
        expData1 = isSetup ? 1'b0 : selOutTog;

        txReqD     = 1'b0;
        txIsData1D = 1'b0;
        hsValidD   = 1'b0;
        hsCodeD    = HS_ACK;
        fillDoneD  = '0;
        fillSuccD  = '0;
        popDoneD   = '0;
        popSuccD   = '0;
        flipOut    = '0;
        flipIn     = '0;
        setBoth    = '0;

        case (state)
            ST_IDLE: begin
                if (accept && (curType == TOK_IN)) begin
                    if (curStall) begin
                        hsValidD = 1'b1;
                        hsCodeD  = HS_STALL;
                    end else if (!curAvail) begin
                        hsValidD = 1'b1;
                        hsCodeD  = HS_NAK;
                    end else begin
                        txReqD     = 1'b1;
                        txIsData1D = curInTog;
                    end
                end
            end
            ST_OUT_DATA: begin
                if (tokValid_i) begin
                    fillDoneD = selOneHot;
                end else if (rxPacketDone_i) begin
                    fillDoneD = selOneHot;
                    if (!rxPacketOk_i) begin
                        hsValidD = 1'b0;
                    end else if (selStall && !isSetup) begin
                        hsValidD = 1'b1;
                        hsCodeD  = HS_STALL;
                    end else if (ovfNow) begin
                        hsValidD = 1'b1;
                        hsCodeD  = HS_NAK;
                    end else if (rxIsData1_i != expData1) begin
                        hsValidD = 1'b1;
                    end else begin
                        hsValidD  = 1'b1;
                        fillSuccD = selOneHot;
                        if (isSetup) begin
                            setBoth = selOneHot;
                        end else begin
                            flipOut = selOneHot;
                        end
                    end
                end
            end
            ST_IN_SEND: begin
                if (tokValid_i) begin
                    popDoneD = selOneHot;
                end
            end
            ST_IN_WAIT_ACK: begin
                if (tokValid_i) begin
                    popDoneD = selOneHot;
                end else if (hostAck_i) begin
                    popDoneD = selOneHot;
                    popSuccD = selOneHot;
                    flipIn   = selOneHot;
                end else if (timeout_i) begin
                    popDoneD = selOneHot;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel                       <= '0;
            isSetup                   <= 1'b0;
            ovf                       <= 1'b0;
            pendValid                 <= 1'b0;
            pendType                  <= '0;
            pendEp                    <= '0;
            txReq_o                   <= 1'b0;
            txIsData1_o               <= 1'b0;
            hsValid_o                 <= 1'b0;
            hsCode_o                  <= '0;
            EP_OUT_fillTransDone_o    <= '0;
            EP_OUT_fillTransSuccess_o <= '0;
            EP_IN_popTransDone_o      <= '0;
            EP_IN_popTransSuccess_o   <= '0;
        end else begin
            if (accept) begin
                sel     <= curEp;
                isSetup <= (curType == TOK_SETUP);
                ovf     <= 1'b0;
            end else if ((state == ST_OUT_DATA) && rxDataValid_i && selFull) begin
                ovf <= 1'b1;
            end
            if ((state != ST_IDLE) && tokValid_i) begin
                pendValid <= 1'b1;
                pendType  <= tokType_i;
                pendEp    <= tokEp_i;
            end else if (state == ST_IDLE) begin
                pendValid <= 1'b0;
            end
            txReq_o <= txReqD;
            if (txReqD) begin
                txIsData1_o <= txIsData1D;
            end
            hsValid_o                 <= hsValidD;
            hsCode_o                  <= hsCodeD;
            EP_OUT_fillTransDone_o    <= fillDoneD;
            EP_OUT_fillTransSuccess_o <= fillSuccD;
            EP_IN_popTransDone_o      <= popDoneD;
            EP_IN_popTransSuccess_o   <= popSuccD;
        end
    end

endmodule

// File: tb/tb_usb_ep_trans_ctrl.sv
// Directed self-checking bench for usb_ep_trans_ctrl; stall cases follow USB_EP_STALL_EN.
module tb_usb_ep_trans_ctrl;

    localparam int EP_CNT = 2;

    logic                clk48_i = 1'b0;
    logic                rst_n_i;
    logic                tokValid_i;
    logic [1:0]          tokType_i;
    logic [3:0]          tokEp_i;
    logic                rxDataValid_i;
    logic [7:0]          rxData_i;
    logic                rxIsData1_i;
    logic                rxPacketDone_i;
    logic                rxPacketOk_i;
    logic                txReq_o;
    logic                txIsData1_o;
    logic                txDataValid_o;
    logic [7:0]          txData_o;
    logic                txPop_i;
    logic                txDone_i;
    logic                hostAck_i;
    logic                timeout_i;
    logic                hsValid_o;
    logic [1:0]          hsCode_o;
    logic [EP_CNT-1:0]   epStall_i;
    logic [EP_CNT-1:0]   EP_OUT_fillTransDone_o;
    logic [EP_CNT-1:0]   EP_OUT_fillTransSuccess_o;
    logic [EP_CNT-1:0]   EP_OUT_dataValid_o;
    logic [7:0]          EP_OUT_data_o;
    logic [EP_CNT-1:0]   EP_OUT_full_i;
    logic [EP_CNT-1:0]   EP_IN_popTransDone_o;
    logic [EP_CNT-1:0]   EP_IN_popTransSuccess_o;
    logic [EP_CNT-1:0]   EP_IN_popData_o;
    logic [EP_CNT-1:0]   EP_IN_dataAvailable_i;
    logic [8*EP_CNT-1:0] EP_IN_data_i;

    int nChecks = 0;
    int nPass   = 0;
    int inCount[EP_CNT];
    int inIdx[EP_CNT];

    usb_ep_trans_ctrl #(
        .EP_CNT(EP_CNT)
    ) dut (
        .clk48_i                  (clk48_i),
        .rst_n_i                  (rst_n_i),
        .tokValid_i               (tokValid_i),
        .tokType_i                (tokType_i),
        .tokEp_i                  (tokEp_i),
        .rxDataValid_i            (rxDataValid_i),
        .rxData_i                 (rxData_i),
        .rxIsData1_i              (rxIsData1_i),
        .rxPacketDone_i           (rxPacketDone_i),
        .rxPacketOk_i             (rxPacketOk_i),
        .txReq_o                  (txReq_o),
        .txIsData1_o              (txIsData1_o),
        .txDataValid_o            (txDataValid_o),
        .txData_o                 (txData_o),
        .txPop_i                  (txPop_i),
        .txDone_i                 (txDone_i),
        .hostAck_i                (hostAck_i),
        .timeout_i                (timeout_i),
        .hsValid_o                (hsValid_o),
        .hsCode_o                 (hsCode_o),
        .epStall_i                (epStall_i),
        .EP_OUT_fillTransDone_o   (EP_OUT_fillTransDone_o),
        .EP_OUT_fillTransSuccess_o(EP_OUT_fillTransSuccess_o),
        .EP_OUT_dataValid_o       (EP_OUT_dataValid_o),
        .EP_OUT_data_o            (EP_OUT_data_o),
        .EP_OUT_full_i            (EP_OUT_full_i),
        .EP_IN_popTransDone_o     (EP_IN_popTransDone_o),
        .EP_IN_popTransSuccess_o  (EP_IN_popTransSuccess_o),
        .EP_IN_popData_o          (EP_IN_popData_o),
        .EP_IN_dataAvailable_i    (EP_IN_dataAvailable_i),
        .EP_IN_data_i             (EP_IN_data_i)
    );

    always #5 clk48_i = ~clk48_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got hang, need completion)");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk48_i);
        #1;
    endtask

    task automatic updateIn();
        for (int e = 0; e < EP_CNT; e++) begin
            EP_IN_dataAvailable_i[e] = (inIdx[e] < inCount[e]);
            EP_IN_data_i[8*e +: 8]   = 8'(8'h50 + 16*e + inIdx[e]);
        end
    endtask

    task automatic doOut(input logic [1:0] typ, input logic [3:0] ep, input logic d1,
                         input int nBytes, input int fullAt, input logic crcOk,
                         output int writes, output int dataErr,
                         output logic [EP_CNT-1:0] done, output logic [EP_CNT-1:0] succ,
                         output logic hsV, output logic [1:0] hsC);
        tokValid_i = 1'b1; tokType_i = typ; tokEp_i = ep;
        tick();
        tokValid_i = 1'b0;
        writes = 0; dataErr = 0;
        for (int i = 0; i < nBytes; i++) begin
            rxDataValid_i = 1'b1;
            rxData_i      = 8'(8'hA0 + i);
            EP_OUT_full_i = (fullAt >= 0 && i >= fullAt) ? '1 : '0;
            #1;
            if (EP_OUT_dataValid_o[ep] === 1'b1) begin
                writes++;
                if (EP_OUT_data_o !== rxData_i) dataErr++;
            end
            if ($countones(EP_OUT_dataValid_o) > 1) dataErr++;
            tick();
        end
        rxDataValid_i = 1'b0; EP_OUT_full_i = '0;
        rxIsData1_i = d1; rxPacketOk_i = crcOk; rxPacketDone_i = 1'b1;
        tick();
        rxPacketDone_i = 1'b0; rxPacketOk_i = 1'b0; rxIsData1_i = 1'b0;
        done = EP_OUT_fillTransDone_o; succ = EP_OUT_fillTransSuccess_o;
        hsV = hsValid_o; hsC = hsCode_o;
    endtask

    task automatic inToken(input logic [3:0] ep, output logic req, output logic d1,
                           output logic hsV, output logic [1:0] hsC);
        tokValid_i = 1'b1; tokType_i = 2'd1; tokEp_i = ep;
        tick();
        tokValid_i = 1'b0;
        req = txReq_o; d1 = txIsData1_o; hsV = hsValid_o; hsC = hsCode_o;
    endtask

    task automatic inBody(input int ep, input bit ack, input bit tmo,
                          output int pops, output int dataErr,
                          output logic [EP_CNT-1:0] done, output logic [EP_CNT-1:0] succ);
        int guard = 0;
        pops = 0; dataErr = 0;
        while (txDataValid_o === 1'b1 && guard < 20) begin
            guard++;
            if (txData_o !== 8'(8'h50 + 16*ep + inIdx[ep])) dataErr++;
            txPop_i = 1'b1;
            #1;
            if (EP_IN_popData_o[ep] === 1'b1) pops++;
            tick();
            txPop_i = 1'b0;
            inIdx[ep]++;
            updateIn();
            #1;
        end
        txDone_i = 1'b1;
        tick();
        txDone_i = 1'b0; hostAck_i = ack; timeout_i = tmo;
        tick();
        hostAck_i = 1'b0; timeout_i = 1'b0;
        done = EP_IN_popTransDone_o; succ = EP_IN_popTransSuccess_o;
        if (ack) inCount[ep] = 0;
        inIdx[ep] = 0;
        updateIn();
        #1;
    endtask

    initial begin
        int writes, dErr, pops;
        logic [EP_CNT-1:0] done, succ;
        logic hsV, req, d1;
        logic [1:0] hsC;

        rst_n_i = 1'b0;
        tokValid_i = 0; tokType_i = 0; tokEp_i = 0;
        rxDataValid_i = 0; rxData_i = 0; rxIsData1_i = 0; rxPacketDone_i = 0; rxPacketOk_i = 0;
        txPop_i = 0; txDone_i = 0; hostAck_i = 0; timeout_i = 0;
        epStall_i = '0; EP_OUT_full_i = '0;
        for (int e = 0; e < EP_CNT; e++) begin inCount[e] = 0; inIdx[e] = 0; end
        updateIn();
        tick(); tick();
        checkVal("rst_hsValid", 32'(hsValid_o), 32'd0);
        checkVal("rst_txReq", 32'(txReq_o), 32'd0);
        checkVal("rst_fillDone", 32'(EP_OUT_fillTransDone_o), 32'd0);
        checkVal("rst_popDone", 32'(EP_IN_popTransDone_o), 32'd0);
        checkVal("rst_txDataValid", 32'(txDataValid_o), 32'd0);
        rst_n_i = 1'b1;
        tick();

        // OUT ep1 DATA0 x4: accepted, toggle -> 1
        doOut(2'd0, 4'd1, 1'b0, 4, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("out1_writes", 32'(writes), 32'd4);
        checkVal("out1_data", 32'(dErr), 32'd0);
        checkVal("out1_done", 32'(done), 32'b10);
        checkVal("out1_succ", 32'(succ), 32'b10);
        checkVal("out1_hs", {30'd0, hsV, hsC[0] | hsC[1]}, {30'd0, 1'b1, 1'b0});
        tick();
        checkVal("out1_pulse", {30'd0, hsValid_o, |EP_OUT_fillTransDone_o}, 32'd0);

        // Duplicate DATA0: ACK but no commit
        doOut(2'd0, 4'd1, 1'b0, 4, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("dup_done", 32'(done), 32'b10);
        checkVal("dup_succ", 32'(succ), 32'b00);
        checkVal("dup_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd0});

        doOut(2'd0, 4'd1, 1'b1, 2, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("out1d1_succ", 32'(succ), 32'b10);

        // IN ep0 empty -> NAK
        inToken(4'd0, req, d1, hsV, hsC);
        checkVal("in0_empty_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd1});
        checkVal("in0_empty_req", 32'(req), 32'd0);
        tick();

        inCount[0] = 3; updateIn();
        inToken(4'd0, req, d1, hsV, hsC);
        checkVal("in0_req", {30'd0, req, d1}, {30'd0, 1'b1, 1'b0});
        checkVal("in0_nohs", 32'(hsV), 32'd0);
        inBody(0, 1'b1, 1'b0, pops, dErr, done, succ);
        checkVal("in0_pops", 32'(pops), 32'd3);
        checkVal("in0_data", 32'(dErr), 32'd0);
        checkVal("in0_done", 32'(done), 32'b01);
        checkVal("in0_succ", 32'(succ), 32'b01);

        // Timeout leaves IN toggle alone; ack+timeout together counts as ack
        inCount[0] = 2; updateIn();
        inToken(4'd0, req, d1, hsV, hsC);
        checkVal("in0b_req", {30'd0, req, d1}, {30'd0, 1'b1, 1'b1});
        inBody(0, 1'b0, 1'b1, pops, dErr, done, succ);
        checkVal("in0_tmo_done", 32'(done), 32'b01);
        checkVal("in0_tmo_succ", 32'(succ), 32'b00);
        inToken(4'd0, req, d1, hsV, hsC);
        checkVal("in0_retry_d1", {30'd0, req, d1}, {30'd0, 1'b1, 1'b1});
        inBody(0, 1'b1, 1'b1, pops, dErr, done, succ);
        checkVal("in0_retry_pops", 32'(pops), 32'd2);
        checkVal("in0_ackwins_succ", 32'(succ), 32'b01);
        inCount[0] = 1; updateIn();
        inToken(4'd0, req, d1, hsV, hsC);
        checkVal("in0c_d1", {30'd0, req, d1}, {30'd0, 1'b1, 1'b0});
        inBody(0, 1'b1, 1'b0, pops, dErr, done, succ);

        // Full after 2 of 5 bytes -> overflow NAK
        doOut(2'd0, 4'd0, 1'b0, 5, 2, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("ovf_writes", 32'(writes), 32'd2);
        checkVal("ovf_done", 32'(done), 32'b01);
        checkVal("ovf_succ", 32'(succ), 32'b00);
        checkVal("ovf_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd1});
        doOut(2'd0, 4'd0, 1'b0, 2, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("post_ovf_writes", 32'(writes), 32'd2);
        checkVal("post_ovf_succ", 32'(succ), 32'b01);

        // Bad CRC: commit fails silently, toggle untouched
        doOut(2'd0, 4'd0, 1'b1, 2, -1, 1'b0, writes, dErr, done, succ, hsV, hsC);
        checkVal("crc_done", 32'(done), 32'b01);
        checkVal("crc_succ_hs", {30'd0, |succ, hsV}, 32'd0);
        doOut(2'd0, 4'd0, 1'b1, 2, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("crc_retry_succ", 32'(succ), 32'b01);

        // Unaddressed endpoint
        tokValid_i = 1'b1; tokType_i = 2'd0; tokEp_i = 4'd5;
        tick();
        tokValid_i = 1'b0;
        checkVal("ep5_noout", {30'd0, hsValid_o, txReq_o}, 32'd0);
        rxDataValid_i = 1'b1; rxData_i = 8'h11;
        #1;
        checkVal("ep5_nowrite", 32'(EP_OUT_dataValid_o), 32'd0);
        tick();
        rxDataValid_i = 1'b0;

        // Abort OUT ep1 with an IN ep0 token; IN then processed from IDLE
        tokValid_i = 1'b1; tokType_i = 2'd0; tokEp_i = 4'd1;
        tick();
        tokValid_i = 1'b0; rxDataValid_i = 1'b1; rxData_i = 8'h22;
        tick();
        rxDataValid_i = 1'b0; tokValid_i = 1'b1; tokType_i = 2'd1; tokEp_i = 4'd0;
        tick();
        tokValid_i = 1'b0;
        checkVal("abort_done", 32'(EP_OUT_fillTransDone_o), 32'b10);
        checkVal("abort_succ_hs", {30'd0, |EP_OUT_fillTransSuccess_o, hsValid_o}, 32'd0);
        tick();
        checkVal("abort_next_hs", {29'd0, hsValid_o, hsCode_o}, {29'd0, 1'b1, 2'd1});
        checkVal("abort_next_nodone", 32'(EP_OUT_fillTransDone_o), 32'd0);
        tick();

        epStall_i = 2'b10;
`ifdef USB_EP_STALL_EN
        inToken(4'd1, req, d1, hsV, hsC);
        checkVal("stall_in_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd2});
        tick();
        doOut(2'd0, 4'd1, 1'b0, 2, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("stall_out_succ", 32'(succ), 32'b00);
        checkVal("stall_out_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd2});
`else
        inToken(4'd1, req, d1, hsV, hsC);
        checkVal("nostall_in_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd1});
        tick();
`endif
        doOut(2'd2, 4'd1, 1'b0, 2, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("setup_done", 32'(done), 32'b10);
        checkVal("setup_succ", 32'(succ), 32'b10);
        checkVal("setup_hs", {29'd0, hsV, hsC}, {29'd0, 1'b1, 2'd0});
        epStall_i = 2'b00;
        inCount[1] = 2; updateIn();
        inToken(4'd1, req, d1, hsV, hsC);
        checkVal("setup_in_d1", {30'd0, req, d1}, {30'd0, 1'b1, 1'b1});
        inBody(1, 1'b1, 1'b0, pops, dErr, done, succ);
        checkVal("in1_data", 32'(dErr), 32'd0);
        checkVal("in1_succ", 32'(succ), 32'b10);
        doOut(2'd0, 4'd1, 1'b1, 1, -1, 1'b1, writes, dErr, done, succ, hsV, hsC);
        checkVal("setup_out_d1_succ", 32'(succ), 32'b10);

        // Reset in the middle of an OUT: no commit afterwards
        tokValid_i = 1'b1; tokType_i = 2'd0; tokEp_i = 4'd0;
        tick();
        tokValid_i = 1'b0; rxDataValid_i = 1'b1; rxData_i = 8'h33;
        tick();
        rxDataValid_i = 1'b0; rxPacketOk_i = 1'b1; rxPacketDone_i = 1'b1; rst_n_i = 1'b0;
        #2;
        checkVal("midrst_outputs", {29'd0, |EP_OUT_fillTransDone_o, hsValid_o, |EP_OUT_dataValid_o}, 32'd0);
        tick();
        rxPacketDone_i = 1'b0; rxPacketOk_i = 1'b0; rst_n_i = 1'b1;
        tick();
        checkVal("midrst_nocommit", {30'd0, |EP_OUT_fillTransDone_o, hsValid_o}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
